// File: rtl/instr_encoder.sv
// instr_encoder: turns a field-level request into an RV32I word, expanding LI into LUI+ADDI.
// One registered output word behind valid/ready; illegal requests pulse err and emit nothing.
module instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [3:0]         req_alu,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic [31:0]        req_imm,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic               err,
    output logic [COUNT_W-1:0] instr_cnt,
    output logic [COUNT_W-1:0] err_cnt
);
    typedef enum logic {IDLE, SECOND} state_t;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    state_t             state_q, state_d;
    logic [31:0]        instr_q, instr_d, pend_q, pend_d, w1, w2;
    logic               valid_q, valid_d, err_q, err_d, two, bad;
    logic [COUNT_W-1:0] icnt_q, icnt_d, ecnt_q, ecnt_d;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [19:0]        lui_hi;
    logic               shift, alu_bad, s12, s13, s21, accept, handoff;
    assign handoff = valid_q && instr_ready;
    assign req_ready = state_q == IDLE && (!valid_q || instr_ready);
    assign accept = req_valid && req_ready;
    assign alu_bad = req_alu > 4'd8;
    assign shift = req_alu == 4'd4 || req_alu == 4'd7 || req_alu == 4'd8;
    assign f7 = (req_alu == 4'd1 || req_alu == 4'd8) ? 7'b0100000 : 7'd0;
    assign f3 = req_alu == 4'd2 ? 3'd7 : req_alu == 4'd3 ? 3'd6 : req_alu == 4'd4 ? 3'd1 :
                req_alu == 4'd5 ? 3'd2 : req_alu == 4'd6 ? 3'd4 : (req_alu == 4'd7 || req_alu == 4'd8) ? 3'd5 : 3'd0;
    // Signed-range fits: all bits above the sign position agree with it.
    assign s12 = &req_imm[31:11] || ~|req_imm[31:11];
    assign s13 = &req_imm[31:12] || ~|req_imm[31:12];
    assign s21 = &req_imm[31:20] || ~|req_imm[31:20];
    // Upper part is rounded so the sign-extended ADDI low part lands on the full value.
    assign lui_hi = req_imm[31:12] + {19'd0, req_imm[11]};
    assign w2 = {req_imm[11:0], req_rd, 3'd0, req_rd, OP_IMM};
    always_comb begin
        w1 = '0;
        two = 1'b0;
        bad = 1'b0;
        case (req_op)
            3'd0: begin
                bad = alu_bad;
                w1 = {f7, req_rs2, req_rs1, f3, req_rd, 7'b0110011};
            end
            3'd1: begin
                bad = alu_bad || req_alu == 4'd1 || (shift ? |req_imm[31:5] : !s12);
                w1 = {shift ? {f7, req_imm[4:0]} : req_imm[11:0], req_rs1, f3, req_rd, OP_IMM};
            end
            3'd2: begin
                bad = !s12;
                w1 = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
            end
            3'd3: begin
                bad = !s12;
                w1 = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
            end
            3'd4: begin
                bad = req_imm[0] || !s13;
                w1 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000, req_imm[4:1], req_imm[11], 7'b1100011};
            end
            3'd5: begin
                bad = req_imm[0] || !s21;
                w1 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
            end
            3'd6: begin
                bad = |req_imm[11:0];
                w1 = {req_imm[31:12], req_rd, OP_LUI};
            end
            3'd7: begin
                w1 = s12 ? {req_imm[11:0], 5'd0, 3'd0, req_rd, OP_IMM} : {lui_hi, req_rd, OP_LUI};
                two = !s12 && |req_imm[11:0];
            end
        endcase
    end
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pend_d = pend_q;
        valid_d = valid_q && !handoff;
        err_d = accept && bad;
        icnt_d = icnt_q + COUNT_W'(handoff);
        ecnt_d = ecnt_q + COUNT_W'(accept && bad);
        if (state_q == SECOND) begin
            if (handoff) begin
                instr_d = pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end else if (accept && !bad) begin
            instr_d = w1;
            pend_d = w2;
            valid_d = 1'b1;
            state_d = two ? SECOND : IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            pend_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
            icnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
            err_q <= err_d;
            icnt_q <= icnt_d;
            ecnt_q <= ecnt_d;
        end
    end
    assign instr_valid = valid_q;
    assign instr = instr_q;
    assign err = err_q;
    assign instr_cnt = icnt_q;
    assign err_cnt = ecnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against an arithmetic
// reference model, with a queue scoreboard drained by an independent monitor.
module tb_instr_encoder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, instr_valid, instr_ready = 1'b0, err;
    logic [2:0]  req_op = '0;
    logic [3:0]  req_alu = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0, instr;
    logic [15:0] instr_cnt, err_cnt;
    int          vec = 0, bad = 0, cyc = 0, pops = 0, errs_exp = 0;
    bit          rnd = 1'b0, held_v = 1'b0;
    logic [31:0] held_w = '0, c0 = '0;
    logic [31:0] sb[$];
    int          errq[$];
    instr_encoder #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_alu(req_alu), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .err(err),
        .instr_cnt(instr_cnt), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // Reference model: builds the word(s) from field positions with shifts and integer ranges.
    function automatic void model(input logic [2:0] op, input logic [3:0] alu, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                                  output bit ill, output int n, output logic [31:0] w1, output logic [31:0] w2);
        logic [2:0] f3t[9] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd1, 3'd2, 3'd4, 3'd5, 3'd5};
        logic [31:0] d = 32'(rd), a = 32'(rs1), b = 32'(rs2), f3, f7, hi, lo;
        int si = $signed(imm);
        bit fit = si >= -2048 && si <= 2047;
        bit sh = alu == 4 || alu == 7 || alu == 8;
        f3 = alu <= 8 ? 32'(f3t[alu]) : 32'd0;
        f7 = (alu == 1 || alu == 8) ? 32'h20 : 32'h0;
        n = 1; ill = 1'b0; w2 = '0;
        lo = imm & 32'hfff;
        case (op)
            3'd0: begin ill = alu > 8; w1 = f7 << 25 | b << 20 | a << 15 | f3 << 12 | d << 7 | 32'h33; end
            3'd1: begin
                ill = alu > 8 || alu == 1 || (sh ? imm > 31 : !fit);
                w1 = (sh ? (f7 << 5 | imm) : lo) << 20 | a << 15 | f3 << 12 | d << 7 | 32'h13;
            end
            3'd2: begin ill = !fit; w1 = lo << 20 | a << 15 | 32'h2 << 12 | d << 7 | 32'h03; end
            3'd3: begin ill = !fit; w1 = (imm >> 5) << 25 | b << 20 | a << 15 | 32'h2 << 12 | (imm & 32'h1f) << 7 | 32'h23; end
            3'd4: begin
                ill = imm[0] || si < -4096 || si > 4094;
                w1 = 32'(imm[12]) << 31 | ((imm >> 5) & 32'h3f) << 25 | b << 20 | a << 15 |
                     ((imm >> 1) & 32'hf) << 8 | 32'(imm[11]) << 7 | 32'h63;
            end
            3'd5: begin
                ill = imm[0] || si < -(1 << 20) || si > (1 << 20) - 2;
                w1 = 32'(imm[20]) << 31 | ((imm >> 1) & 32'h3ff) << 21 | 32'(imm[11]) << 20 |
                     ((imm >> 12) & 32'hff) << 12 | d << 7 | 32'h6f;
            end
            3'd6: begin ill = lo != 0; w1 = (imm & 32'hfffff000) | d << 7 | 32'h37; end
            default: begin
                hi = (imm + 32'h800) >> 12;
                if (fit) w1 = lo << 20 | d << 7 | 32'h13;
                else begin
                    w1 = hi << 12 | d << 7 | 32'h37;
                    w2 = lo << 20 | d << 15 | d << 7 | 32'h13;
                    n = lo != 0 ? 2 : 1;
                end
            end
        endcase
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) instr_ready = ($urandom % 4) != 0;
    endtask
    task automatic send(input logic [2:0] op, input logic [3:0] alu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bit acc = 1'b0, ill;
        int n;
        logic [31:0] w1, w2;
        req_op = op; req_alu = alu; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                model(op, alu, rd, rs1, rs2, imm, ill, n, w1, w2);
                if (ill) begin errq.push_back(cyc + 1); errs_exp++; end
                else begin sb.push_back(w1); if (n == 2) sb.push_back(w2); end
            end
            step();
        end
        req_valid = 1'b0;
        if (!acc) begin vec++; bad++; $display("FAIL accept_timeout: req_ready never high for op %0d", op); end
    endtask
    initial forever begin
        @(negedge clk);
        if (rst) held_v = 1'b0;
        else begin
            if (errq.size() > 0 && errq[0] == cyc) begin chk("err_pulse", 32'(err), 1); void'(errq.pop_front()); end
            else chk("err_idle", 32'(err), 0);
            if (held_v) begin chk("hold_valid", 32'(instr_valid), 1); chk("hold_word", instr, held_w); end
            held_v = instr_valid && !instr_ready;
            held_w = instr;
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin vec++; bad++; $display("FAIL word_unexpected: got %h expected none", instr); end
                else begin chk("word", instr, sb.pop_front()); pops++; end
            end
        end
    end
    function automatic logic [31:0] rimm();
        int bnd[14] = '{-2048, -2049, 2047, 2048, 4094, 4095, -4096, -4098, (1 << 20) - 2, 1 << 20,
                         -(1 << 20), -(1 << 20) - 2, 32'h800, 31};
        case ($urandom % 6)
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return 32'($urandom_range(0, 40));
            2: return 32'(bnd[$urandom % 14]);
            3: return $urandom;
            4: return $urandom & 32'hfffff000;
            default: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
        endcase
    endfunction
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 0); chk("rst_instr", instr, 0); chk("rst_err", 32'(err), 0);
        chk("rst_icnt", 32'(instr_cnt), 0); chk("rst_ecnt", 32'(err_cnt), 0);
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("rst_ready", 32'(req_ready), 1);
        send(3'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0); chk("add", instr, 32'h002081B3);
        send(3'd0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0); chk("sub", instr, 32'h402081B3);
        repeat (3) step();
        c0 = 32'(instr_cnt);
        send(3'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        chk("li_lui", instr, 32'h123452B7); chk("li_ready_low", 32'(req_ready), 0);
        step();
        chk("li_addi", instr, 32'h67828293); chk("li_ready_back", 32'(req_ready), 1);
        step();
        chk("li_cnt2", 32'(instr_cnt), c0 + 2);
        send(3'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h800); chk("li800_lui", instr, 32'h000012B7);
        step(); chk("li800_addi", instr, 32'h80028293);
        send(3'd7, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF); chk("li_m1", instr, 32'hFFF00093);
        step(); chk("li_m1_single", 32'(instr_valid), 0);
        send(3'd7, 4'd0, 5'd2, 5'd0, 5'd0, 32'h1000); chk("li1000", instr, 32'h00001137);
        step(); chk("li1000_single", 32'(instr_valid), 0);
        c0 = 32'(err_cnt);
        send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        chk("beq_err", 32'(err), 1); chk("beq_novalid", 32'(instr_valid), 0);
        step(); chk("beq_err_end", 32'(err), 0);
        send(3'd1, 4'd1, 5'd3, 5'd1, 5'd0, 32'd5);
        chk("isub_err", 32'(err), 1); chk("isub_novalid", 32'(instr_valid), 0);
        step(); chk("isub_err_end", 32'(err), 0); chk("ecnt2", 32'(err_cnt), c0 + 2);
        instr_ready = 1'b0;
        send(3'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            chk("stall_word", instr, 32'h123452B7); chk("stall_ready", 32'(req_ready), 0);
            step();
        end
        instr_ready = 1'b1;
        step(); chk("stall_addi", instr, 32'h67828293);
        step();
        instr_ready = 1'b0;
        send(3'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        chk("rst2_valid", 32'(instr_valid), 0); chk("rst2_instr", instr, 0); chk("rst2_err", 32'(err), 0);
        chk("rst2_icnt", 32'(instr_cnt), 0); chk("rst2_ecnt", 32'(err_cnt), 0); chk("rst2_ready", 32'(req_ready), 1);
        sb.delete(); errq.delete(); pops = 0; errs_exp = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        instr_ready = 1'b1;
        step();
        send(3'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345678); chk("rst2_lui", instr, 32'h123452B7);
        step(); chk("rst2_addi", instr, 32'h67828293);
        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) step();
            send(3'($urandom), ($urandom % 10 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                 5'($urandom), 5'($urandom), 5'($urandom), rimm());
        end
        rnd = 1'b0;
        instr_ready = 1'b1;
        for (int t = 0; t < 40 && (sb.size() != 0 || instr_valid); t++) step();
        step();
        chk("drain_left", 32'(sb.size()), 0);
        chk("err_left", 32'(errq.size()), 0);
        chk("final_icnt", 32'(instr_cnt), 32'(pops) & 32'hffff);
        chk("final_ecnt", 32'(err_cnt), 32'(errs_exp) & 32'hffff);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
